// File: rtl/score_history_sched_if.sv
// Bus bundle between score_history_sched, its three requesters and the 8x13 score register file.
interface score_history_sched_if #(
    parameter int WIDTH = 13
);
    logic             clearReq;
    logic             scoreValid;
    logic [WIDTH-1:0] scoreData;
    logic             scoreReady;
    logic             dispReq;
    logic [2:0]       dispAddr;
    logic             dispAck;
    logic [WIDTH-1:0] dispData;
    logic [2:0]       ReadP;
    logic [WIDTH-1:0] registerDataP;
    logic [2:0]       WriteAddress;
    logic [WIDTH-1:0] registerLoadData;
    logic             registerLoad;
    logic [WIDTH-1:0] bestScore;
    logic             busy;

    modport slave (
        input  clearReq, scoreValid, scoreData, dispReq, dispAddr, registerDataP,
        output scoreReady, dispAck, dispData, ReadP, WriteAddress,
               registerLoadData, registerLoad, bestScore, busy
    );

    modport master (
        output clearReq, scoreValid, scoreData, dispReq, dispAddr, registerDataP,
        input  scoreReady, dispAck, dispData, ReadP, WriteAddress,
               registerLoadData, registerLoad, bestScore, busy
    );
endinterface

// File: rtl/score_history_sched.sv
// Sequencer/arbiter sharing the score register file between score submit, display read and clear.
// Best-score tracking is built only when SCORE_BEST_TRACK_EN is defined; otherwise bestScore is all-ones.
module score_history_sched #(
    parameter int WIDTH   = 13,
    parameter int PTR_MAX = 7
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    score_history_sched_if.slave bus
);
    localparam logic [2:0]       PTR_MAX_C = 3'(PTR_MAX);
    localparam logic [WIDTH-1:0] BEST_INIT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_RD   = 3'd1,
        SCORE_WR = 3'd2,
        PTR_WR   = 3'd3,
        DISP_ACK = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] scoreLat_r;
    logic [WIDTH-1:0] wrData_r;
    logic [WIDTH-1:0] dispData_r;
    logic [2:0]       ptr_r;
    logic [2:0]       cnt_r;
    logic [2:0]       wrAddr_r;
    logic             regLoad_r;
    logic             dispAck_r;
    logic             busy_r;

    logic             isIdle_s;
    logic             clrGrant_s;
    logic             scoreGrant_s;
    logic             dispGrant_s;
    logic [2:0]       readP_s;
    logic [2:0]       ptrRd_s;

    function automatic logic [2:0] nextPtr(input logic [2:0] p);
        if (p == PTR_MAX_C) begin
            return 3'd1;
        end else begin
            return p + 3'd1;
        end
    endfunction

    // Fixed-priority grant decode, read-port steering and pointer recovery
    always_comb begin
        isIdle_s     = (state_r == IDLE);
        clrGrant_s   = isIdle_s & bus.clearReq;
        scoreGrant_s = isIdle_s & ~bus.clearReq & bus.scoreValid;
        dispGrant_s  = isIdle_s & ~bus.clearReq & ~bus.scoreValid & bus.dispReq;
        if (dispGrant_s) begin
            readP_s = bus.dispAddr;
        end else begin
            readP_s = 3'd0;
        end
        // An uninitialised file has pointer 0; start history at slot 1 instead.
        if (bus.registerDataP[2:0] == 3'd0) begin
            ptrRd_s = 3'd1;
        end else begin
            ptrRd_s = bus.registerDataP[2:0];
        end
    end

    // Main sequencer; all write-port and handshake outputs are registered here
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_r    <= IDLE;
            scoreLat_r <= ZERO_W;
            wrData_r   <= ZERO_W;
            dispData_r <= ZERO_W;
            ptr_r      <= 3'd0;
            cnt_r      <= 3'd0;
            wrAddr_r   <= 3'd0;
            regLoad_r  <= 1'b0;
            dispAck_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dispAck_r <= 1'b0;
                    if (clrGrant_s) begin
                        state_r   <= CLEAR;
                        cnt_r     <= 3'd0;
                        wrAddr_r  <= 3'd0;
                        wrData_r  <= {{(WIDTH-1){1'b0}}, 1'b1};
                        regLoad_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (scoreGrant_s) begin
                        state_r    <= PTR_RD;
                        scoreLat_r <= bus.scoreData;
                        regLoad_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end else if (dispGrant_s) begin
                        state_r    <= DISP_ACK;
                        dispData_r <= bus.registerDataP;
                        dispAck_r  <= 1'b1;
                        regLoad_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        regLoad_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                PTR_RD: begin
                    state_r   <= SCORE_WR;
                    ptr_r     <= ptrRd_s;
                    wrAddr_r  <= ptrRd_s;
                    wrData_r  <= scoreLat_r;
                    regLoad_r <= 1'b1;
                end
                SCORE_WR: begin
                    state_r   <= PTR_WR;
                    wrAddr_r  <= 3'd0;
                    wrData_r  <= {{(WIDTH-3){1'b0}}, nextPtr(ptr_r)};
                    regLoad_r <= 1'b1;
                end
                PTR_WR: begin
                    state_r   <= IDLE;
                    regLoad_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
                DISP_ACK: begin
                    state_r   <= IDLE;
                    dispAck_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
                CLEAR: begin
                    if (cnt_r == 3'd7) begin
                        state_r   <= IDLE;
                        cnt_r     <= 3'd0;
                        regLoad_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + 3'd1;
                        wrAddr_r  <= cnt_r + 3'd1;
                        wrData_r  <= ZERO_W;
                        regLoad_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    regLoad_r <= 1'b0;
                    dispAck_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_BEST_TRACK_EN
    logic [WIDTH-1:0] best_r;

    // Lowest non-zero stored score; back to all-ones on reset or clear grant
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            best_r <= BEST_INIT;
        end else if (clrGrant_s) begin
            best_r <= BEST_INIT;
        end else if ((state_r == SCORE_WR) && (scoreLat_r != ZERO_W) && (scoreLat_r < best_r)) begin
            best_r <= scoreLat_r;
        end else begin
            best_r <= best_r;
        end
    end

    assign bus.bestScore = best_r;
`else
    assign bus.bestScore = BEST_INIT;
`endif

    assign bus.scoreReady       = isIdle_s & ~bus.clearReq;
    assign bus.ReadP            = readP_s;
    assign bus.WriteAddress     = wrAddr_r;
    assign bus.registerLoadData = wrData_r;
    assign bus.registerLoad     = regLoad_r;
    assign bus.dispAck          = dispAck_r;
    assign bus.dispData         = dispData_r;
    assign bus.busy             = busy_r;
endmodule

// File: tb/tb_score_history_sched.sv
// Scoreboard bench for score_history_sched: a reference model queues expected file writes and
// display results, a monitor compares them as the DUT presents them, directed tasks check timing.
module tb_score_history_sched;
    localparam logic [12:0] INIT_RF [8] = '{13'h1B00, 13'h0AAA, 13'h0555, 13'h1234,
                                            13'h0F0F, 13'h00FF, 13'h1001, 13'h0777};

    typedef struct {
        logic [2:0]  a;
        logic [12:0] d;
    } wr_t;

    logic Clock = 1'b0;
    logic ResetN;
    score_history_sched_if #(.WIDTH(13)) ifc ();

    score_history_sched #(.WIDTH(13), .PTR_MAX(7)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (ifc.slave)
    );

    always #5 Clock = ~Clock;

    // Register file seen by the DUT: combinational P read, synchronous write
    logic [12:0] rf [8] = INIT_RF;
    assign ifc.registerDataP = rf[ifc.ReadP];
    always @(posedge Clock) begin
        if (ifc.registerLoad === 1'b1) rf[ifc.WriteAddress] <= ifc.registerLoadData;
    end

    int nCmp = 0;
    int nBad = 0;
    wr_t         wq [$];
    logic [12:0] dq [$];
    logic [12:0] refFile [8];
    logic [12:0] refBest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        nCmp++;
        nBad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: history is a ring over slots 1..7, slot pointer kept in entry 0
    function automatic void mClear();
        for (int i = 0; i < 8; i++) begin
            refFile[i] = (i == 0) ? 13'd1 : 13'd0;
            wq.push_back('{a: 3'(i), d: refFile[i]});
        end
        refBest = 13'h1FFF;
    endfunction

    function automatic int mScore(input logic [12:0] s);
        int p;
        p = int'(refFile[0][2:0]);
        if (p == 0) p = 1;
        refFile[p] = s;
        wq.push_back('{a: 3'(p), d: s});
        refFile[0] = 13'(p % 7 + 1);
        wq.push_back('{a: 3'd0, d: refFile[0]});
`ifdef SCORE_BEST_TRACK_EN
        if (s != 13'd0 && s < refBest) refBest = s;
`endif
        return p;
    endfunction

    function automatic void mDisp(input logic [2:0] a);
        dq.push_back(refFile[a]);
    endfunction

    // Monitor: compare every write and display ack against the model queues
    always @(negedge Clock) begin
        if (ifc.registerLoad === 1'b1 || ifc.dispAck === 1'b1) begin
            check("ackLoadOverlap", 32'(ifc.registerLoad & ifc.dispAck), 32'd0);
            if (ifc.registerLoad === 1'b1) begin
                if (wq.size() == 0) begin
                    failNow("unexpectedWrite");
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("writeAddr", 32'(ifc.WriteAddress), 32'(e.a));
                    check("writeData", 32'(ifc.registerLoadData), 32'(e.d));
                end
            end
            if (ifc.dispAck === 1'b1) begin
                if (dq.size() == 0) begin
                    failNow("unexpectedAck");
                end else begin
                    logic [12:0] e;
                    e = dq.pop_front();
                    check("dispData", 32'(ifc.dispData), 32'(e));
                end
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (ifc.busy !== 1'b0 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 40) failNow("idleTimeout");
    endtask

    task automatic directClear();
        mClear();
        ifc.clearReq = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        ifc.clearReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("clearBusy", 32'(ifc.busy), 32'd1);
            check("clearLoad", 32'(ifc.registerLoad), 32'd1);
            check("clearAddr", 32'(ifc.WriteAddress), 32'(i));
            @(negedge Clock);
        end
        check("clearDoneBusy", 32'(ifc.busy), 32'd0);
        check("clearDoneLoad", 32'(ifc.registerLoad), 32'd0);
        check("clearBest", 32'(ifc.bestScore), 32'h1FFF);
    endtask

    task automatic directScore(input logic [12:0] sd, input int expSlot);
        int slot;
        slot = mScore(sd);
        check("modelSlot", 32'(slot), 32'(expSlot));
        ifc.scoreValid = 1'b1;
        ifc.scoreData  = sd;
        #1;
        check("scoreReady", 32'(ifc.scoreReady), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        ifc.scoreValid = 1'b0;
        check("ptrRdBusy", 32'(ifc.busy), 32'd1);
        check("ptrRdLoad", 32'(ifc.registerLoad), 32'd0);
        @(negedge Clock);
        check("scoreWrLoad", 32'(ifc.registerLoad), 32'd1);
        check("scoreWrAddr", 32'(ifc.WriteAddress), 32'(expSlot));
        @(negedge Clock);
        check("ptrWrLoad", 32'(ifc.registerLoad), 32'd1);
        check("ptrWrAddr", 32'(ifc.WriteAddress), 32'd0);
        @(negedge Clock);
        check("scoreDoneBusy", 32'(ifc.busy), 32'd0);
        check("best", 32'(ifc.bestScore), 32'(refBest));
    endtask

    task automatic directDisp(input logic [2:0] a, input logic [12:0] expData);
        mDisp(a);
        ifc.dispReq  = 1'b1;
        ifc.dispAddr = a;
        #1;
        check("ReadP", 32'(ifc.ReadP), 32'(a));
        @(posedge Clock);
        @(negedge Clock);
        ifc.dispReq = 1'b0;
        check("dispAckHigh", 32'(ifc.dispAck), 32'd1);
        check("dispDataDirect", 32'(ifc.dispData), 32'(expData));
        @(negedge Clock);
        check("dispAckLow", 32'(ifc.dispAck), 32'd0);
        check("dispHeld", 32'(ifc.dispData), 32'(expData));
    endtask

    // Issue any mix of requests together; requesters hold until their grant
    task automatic runRound(input bit c, input bit s, input bit d,
                            input logic [12:0] sd, input logic [2:0] da);
        bit pc, ps, pd;
        int budget = 0;
        int unused;
        waitIdle();
        if (c) mClear();
        if (s) unused = mScore(sd);
        if (d) mDisp(da);
        ifc.clearReq   = c;
        ifc.scoreValid = s;
        ifc.scoreData  = sd;
        ifc.dispReq    = d;
        ifc.dispAddr   = da;
        #1;
        check("scoreReadyArb", 32'(ifc.scoreReady), 32'(!c));
        pc = c; ps = s; pd = d;
        while ((pc || ps || pd) && budget < 60) begin
            if (ifc.busy === 1'b0) begin
                @(posedge Clock);
                @(negedge Clock);
                if (pc) begin
                    pc = 1'b0; ifc.clearReq = 1'b0;
                end else if (ps) begin
                    ps = 1'b0; ifc.scoreValid = 1'b0;
                end else begin
                    pd = 1'b0; ifc.dispReq = 1'b0;
                end
            end else begin
                @(negedge Clock);
            end
            budget++;
        end
        if (budget >= 60) failNow("grantTimeout");
        waitIdle();
        check("roundBest", 32'(ifc.bestScore), 32'(refBest));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] sd;
        logic [12:0] ws [8];
        bit c, s, d;
        for (int i = 0; i < 8; i++) refFile[i] = INIT_RF[i];
        refBest = 13'h1FFF;

        // Reset with every request asserted
        ResetN         = 1'b0;
        ifc.clearReq   = 1'b1;
        ifc.scoreValid = 1'b1;
        ifc.scoreData  = 13'h0155;
        ifc.dispReq    = 1'b1;
        ifc.dispAddr   = 3'd3;
        repeat (2) @(negedge Clock);
        check("rstBusy", 32'(ifc.busy), 32'd0);
        check("rstLoad", 32'(ifc.registerLoad), 32'd0);
        check("rstAck", 32'(ifc.dispAck), 32'd0);
        check("rstBest", 32'(ifc.bestScore), 32'h1FFF);
        check("rstDispData", 32'(ifc.dispData), 32'd0);
        ifc.clearReq   = 1'b0;
        ifc.scoreValid = 1'b0;
        ifc.dispReq    = 1'b0;
        ResetN         = 1'b1;
        @(negedge Clock);

        // Pointer field of entry 0 is 0 before any clear: history starts at slot 1
        directScore(13'h0321, 1);
        directClear();
        directScore(13'h0123, 1);

        // Display and best score
        directClear();
        directScore(13'h0200, 1);
        directScore(13'h0050, 2);
        directScore(13'h0000, 3);
`ifdef SCORE_BEST_TRACK_EN
        check("bestLowest", 32'(ifc.bestScore), 32'h0050);
`else
        check("bestTied", 32'(ifc.bestScore), 32'h1FFF);
`endif
        directDisp(3'd2, 13'h0050);

        // Wrap: eighth score lands back in slot 1
        directClear();
        for (int i = 0; i < 8; i++) begin
            ws[i] = 13'($urandom);
            directScore(ws[i], (i % 7) + 1);
        end
        directDisp(3'd0, 13'd2);
        directDisp(3'd1, ws[7]);
        directDisp(3'd7, ws[6]);

        // All three requesters together
        runRound(1'b1, 1'b1, 1'b1, 13'h0444, 3'd1);
        runRound(1'b0, 1'b1, 1'b1, 13'h0011, 3'd2);

        for (int r = 0; r < 200; r++) begin
            c = ($urandom_range(0, 11) == 0);
            s = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!c && !s && !d) s = 1'b1;
            case ($urandom_range(0, 3))
                0:       sd = 13'd0;
                1:       sd = 13'($urandom_range(1, 40));
                default: sd = 13'($urandom);
            endcase
            runRound(c, s, d, sd, 3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge Clock);
        check("writeQueueDrained", 32'(wq.size()), 32'd0);
        check("dispQueueDrained", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
